dqsw_training_sequencer: RTL and testbench

- Sequences DQSW/DQSW270 write-leveling training for one DDR3 PHY lane IOD. Drives the IOD dynamic delay-line controls and reads its eye-monitor flags.
- Sweeps the delay tap upward one tap at a time and samples the early/late flags at each tap. Stops at the first early-to-late transition and reports that tap.
- Sits between the DDR3 PHY training controller (start/done handshake) and the lane IOD.

---
 rtl/dqsw_training_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_dqsw_training_sequencer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/dqsw_training_sequencer.sv
// DQSW write-leveling training sequencer: sweeps one lane IOD delay tap upward to the first early->late edge.
// Latency: LOAD one cycle after an accepted start; each tap costs SETTLE_CYCLES+SAMPLE_CYCLES+3 cycles.
// No backpressure: TRAIN_START is honoured only in IDLE/DONE/ERR and silently dropped while BUSY.
module dqsw_training_sequencer #(
  parameter int MAX_TAPS      = 128,
  parameter int TAP_W         = 7,
  parameter int SETTLE_CYCLES = 8,
  parameter int SAMPLE_CYCLES = 16
) (
  input  logic             FAB_CLK,
  input  logic             RESET,
  input  logic             TRAIN_START,
  output logic             BUSY,
  output logic             TRAIN_DONE,
  output logic             TRAIN_ERR,
  output logic [1:0]       ERR_CODE,
  output logic [TAP_W-1:0] TAP_RESULT,
  output logic             DELAY_LINE_LOAD,
  output logic             DELAY_LINE_MOVE,
  output logic             DELAY_LINE_DIRECTION,
  input  logic             DELAY_LINE_OUT_OF_RANGE,
  output logic             EYE_MONITOR_CLEAR_FLAGS,
  input  logic             EYE_MONITOR_EARLY,
  input  logic             EYE_MONITOR_LATE
);

  // One shared counter times both SETTLE and SAMPLE, so size it for the longer of the two.
  localparam int CNT_MAX = (SETTLE_CYCLES > SAMPLE_CYCLES) ? SETTLE_CYCLES : SAMPLE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [1:0] CODE_NO_EDGE = 2'b01;
  localparam logic [1:0] CODE_RANGE   = 2'b10;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CLEAR,
    ST_SETTLE,
    ST_SAMPLE,
    ST_EVAL,
    ST_STEP,
    ST_DONE,
    ST_ERR
  } state_t;

  state_t             state_q, state_d;
  logic [TAP_W-1:0]   tap_cnt_q, tap_cnt_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               armed_q, armed_d;
  logic               e_acc_q, e_acc_d;
  logic               l_acc_q, l_acc_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [1:0]         code_q, code_d;
  logic [TAP_W-1:0]   result_q, result_d;
  logic               busy_q, busy_d;
  logic               load_q, load_d;
  logic               move_q, move_d;
  logic               clear_q, clear_d;

  // Next-state, datapath and status computation; pulses are derived from the next state so they
  // come out of flops aligned with the state they belong to.
  always_comb begin
    state_d   = state_q;
    tap_cnt_d = tap_cnt_q;
    cnt_d     = cnt_q;
    armed_d   = armed_q;
    e_acc_d   = e_acc_q;
    l_acc_d   = l_acc_q;
    done_d    = done_q;
    err_d     = err_q;
    code_d    = code_q;
    result_d  = result_q;

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (TRAIN_START) begin
          state_d   = ST_LOAD;
          done_d    = 1'b0;
          err_d     = 1'b0;
          code_d    = 2'b00;
          result_d  = '0;
          tap_cnt_d = '0;
          armed_d   = 1'b0;
        end
      end
      ST_LOAD: state_d = ST_CLEAR;
      ST_CLEAR: begin
        e_acc_d = 1'b0;
        l_acc_d = 1'b0;
        cnt_d   = '0;
        state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (DELAY_LINE_OUT_OF_RANGE) begin
          state_d = ST_ERR;
          err_d   = 1'b1;
          code_d  = CODE_RANGE;
        end else if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = ST_SAMPLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_SAMPLE: begin
        e_acc_d = e_acc_q | EYE_MONITOR_EARLY;
        l_acc_d = l_acc_q | EYE_MONITOR_LATE;
        if (cnt_q == CNT_W'(SAMPLE_CYCLES - 1)) begin
          state_d = ST_EVAL;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_EVAL: begin
        // An edge needs a clean EARLY tap immediately before the LATE tap; anything else re-arms.
        if (armed_q && l_acc_q) begin
          state_d  = ST_DONE;
          done_d   = 1'b1;
          result_d = tap_cnt_q;
        end else begin
          armed_d = e_acc_q & ~l_acc_q;
          if (tap_cnt_q == TAP_W'(MAX_TAPS - 1)) begin
            state_d = ST_ERR;
            err_d   = 1'b1;
            code_d  = CODE_NO_EDGE;
          end else begin
            state_d = ST_STEP;
          end
        end
      end
      ST_STEP: begin
        tap_cnt_d = tap_cnt_q + TAP_W'(1);
        state_d   = ST_CLEAR;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d  = !(state_d == ST_IDLE || state_d == ST_DONE || state_d == ST_ERR);
    load_d  = (state_d == ST_LOAD);
    move_d  = (state_d == ST_STEP);
    clear_d = (state_d == ST_CLEAR);
  end

  // State and output registers; reset aborts any sequence and drops every pulse at once.
  always_ff @(posedge FAB_CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      tap_cnt_q <= '0;
      cnt_q     <= '0;
      armed_q   <= 1'b0;
      e_acc_q   <= 1'b0;
      l_acc_q   <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      code_q    <= 2'b00;
      result_q  <= '0;
      busy_q    <= 1'b0;
      load_q    <= 1'b0;
      move_q    <= 1'b0;
      clear_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      tap_cnt_q <= tap_cnt_d;
      cnt_q     <= cnt_d;
      armed_q   <= armed_d;
      e_acc_q   <= e_acc_d;
      l_acc_q   <= l_acc_d;
      done_q    <= done_d;
      err_q     <= err_d;
      code_q    <= code_d;
      result_q  <= result_d;
      busy_q    <= busy_d;
      load_q    <= load_d;
      move_q    <= move_d;
      clear_q   <= clear_d;
    end
  end

  assign BUSY                    = busy_q;
  assign TRAIN_DONE              = done_q;
  assign TRAIN_ERR               = err_q;
  assign ERR_CODE                = code_q;
  assign TAP_RESULT              = result_q;
  assign DELAY_LINE_LOAD         = load_q;
  assign DELAY_LINE_MOVE         = move_q;
  assign DELAY_LINE_DIRECTION    = move_q;
  assign EYE_MONITOR_CLEAR_FLAGS = clear_q;

endmodule

// File: tb/tb_dqsw_training_sequencer.sv
// Self-checking bench for dqsw_training_sequencer: per-tap flag patterns drive an outcome model
// that predicts every output on every cycle from the tap sweep rules.
module tb_dqsw_training_sequencer;

  localparam int S  = 8;
  localparam int N  = 16;
  localparam int P  = S + N + 3;
  localparam int MT = 128;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       oor = 1'b0;
  logic       early = 1'b0;
  logic       late = 1'b0;
  logic       busy, done, err, load, move, dir, clr;
  logic [1:0] code;
  logic [6:0] tap_res;
  logic [15:0] out_vec;

  dqsw_training_sequencer dut (
    .FAB_CLK(clk),
    .RESET(rst),
    .TRAIN_START(start),
    .BUSY(busy),
    .TRAIN_DONE(done),
    .TRAIN_ERR(err),
    .ERR_CODE(code),
    .TAP_RESULT(tap_res),
    .DELAY_LINE_LOAD(load),
    .DELAY_LINE_MOVE(move),
    .DELAY_LINE_DIRECTION(dir),
    .DELAY_LINE_OUT_OF_RANGE(oor),
    .EYE_MONITOR_CLEAR_FLAGS(clr),
    .EYE_MONITOR_EARLY(early),
    .EYE_MONITOR_LATE(late)
  );

  always #5 clk = ~clk;

  assign out_vec = {busy, load, clr, move, dir, done, err, code, tap_res};

  bit early_a[MT];
  bit late_a[MT];
  int oor_tap = -1;
  int cyc = 0;
  bit active = 1'b0;
  bit arm = 1'b0;
  int m_end, m_kind, m_code, m_result, m_moves;
  int load_cnt = 0;
  int move_cnt = 0;
  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Outcome of a sweep from the per-tap flag pattern: kind 0 = edge found, 1 = error.
  function automatic void model();
    bit armed = 1'b0;
    for (int k = 0; k < MT; k++) begin
      if (k == oor_tap) begin
        m_kind = 1; m_code = 2; m_result = 0; m_moves = k; m_end = 4 + k * P;
        return;
      end
      if (armed && late_a[k]) begin
        m_kind = 0; m_code = 0; m_result = k; m_moves = k; m_end = (k + 1) * P + 1;
        return;
      end
      armed = early_a[k] && !late_a[k];
    end
    m_kind = 1; m_code = 1; m_result = 0; m_moves = MT - 1; m_end = MT * P + 1;
  endfunction

  task automatic set_pattern(input int kind);
    for (int k = 0; k < MT; k++) begin
      case (kind)
        0: begin early_a[k] = (k < 10); late_a[k] = (k >= 10); end
        1: begin early_a[k] = (k <= 3) || (k == 6) || (k == 7); late_a[k] = (k == 5) || (k == 8); end
        default: begin early_a[k] = 1'b1; late_a[k] = 1'b0; end
      endcase
    end
    oor_tap = (kind == 3) ? 20 : -1;
  endtask

  // Per-cycle monitor: predicts the full output vector, counts pulses, drives the IOD flags.
  initial begin
    logic [15:0] exp_v;
    bit b_e, ld_e, cl_e, mv_e, dn_e, er_e;
    int tap;
    forever begin
      @(posedge clk);
      #1;
      if (arm) begin
        arm = 1'b0; active = 1'b1; cyc = 1; load_cnt = 0; move_cnt = 0;
      end else if (active) begin
        cyc++;
      end
      exp_v = '0;
      if (active) begin
        b_e  = cyc < m_end;
        ld_e = (cyc == 1);
        cl_e = b_e && cyc >= 2 && ((cyc - 2) % P == 0) && ((cyc - 2) / P <= m_moves);
        mv_e = b_e && cyc >= P + 1 && ((cyc - 1) % P == 0) && ((cyc - 1) / P - 1 < m_moves);
        dn_e = !b_e && m_kind == 0;
        er_e = !b_e && m_kind == 1;
        exp_v = {b_e, ld_e, cl_e, mv_e, mv_e, dn_e, er_e,
                 er_e ? 2'(m_code) : 2'b00, dn_e ? 7'(m_result) : 7'd0};
      end
      n_checks++;
      if (out_vec !== exp_v) begin
        n_fail++;
        $display("FAIL cycle_outputs at run cycle %0d: got %h expected %h", cyc, out_vec, exp_v);
      end
      if (load === 1'b1) load_cnt++;
      if (move === 1'b1) move_cnt++;
      tap = (active && cyc >= 2) ? (cyc - 2) / P : 0;
      if (tap > MT - 1) tap = MT - 1;
      early = active && early_a[tap];
      late  = active && late_a[tap];
      oor   = active && (tap == oor_tap);
    end
  end

  // One training run; optional START spam while BUSY and optional reset abort at a run cycle.
  task automatic run(input bit spam, input int abort_at);
    int n;
    @(negedge clk);
    model();
    start = 1'b1;
    arm = 1'b1;
    n = (abort_at > 0) ? abort_at : m_end + 2;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i == 0) begin
        check("start_load_pulse", load, 1);
        check("start_clears_done", done, 0);
        check("start_clears_err", err, 0);
      end
      start = spam ? busy : 1'b0;
    end
    start = 1'b0;
    if (abort_at > 0) begin
      rst = 1'b1;
      active = 1'b0;
      repeat (3) @(negedge clk);
      check("abort_reset_outputs", out_vec, 0);
      rst = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_outputs", out_vec, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Edge at tap 10, START hammered while BUSY.
    set_pattern(0);
    run(1'b1, 0);
    check("edge_model_end", m_end, 298);
    check("edge_done", done, 1);
    check("edge_tap", tap_res, 10);
    check("edge_code", code, 0);
    check("edge_moves", move_cnt, 10);
    check("edge_single_load", load_cnt, 1);

    // Re-arm rule, started from DONE.
    set_pattern(1);
    run(1'b0, 0);
    check("rearm_done", done, 1);
    check("rearm_tap", tap_res, 8);

    // No edge anywhere.
    set_pattern(2);
    run(1'b0, 0);
    check("noedge_err", err, 1);
    check("noedge_code", code, 1);
    check("noedge_tap", tap_res, 0);
    check("noedge_moves", move_cnt, 127);

    // Out of range during SETTLE of tap 20, started from ERR.
    set_pattern(3);
    run(1'b0, 0);
    check("oor_model_end", m_end, 544);
    check("oor_err", err, 1);
    check("oor_code", code, 2);
    check("oor_moves", move_cnt, 20);

    // Reset in the middle of SAMPLE of tap 3, then a clean restart.
    set_pattern(0);
    run(1'b0, 95);
    run(1'b0, 0);
    check("restart_tap", tap_res, 10);
    check("restart_moves", move_cnt, 10);
    check("restart_single_load", load_cnt, 1);
    check("restart_done", done, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
